// File: rtl/regrw16_arbiter_if.sv
// Avalon-MM register-access port bundle shared by the upstream masters.
//   writedata/byteenable/write/read : request side, driven by the master
//   waitrequest                     : low for the single cycle a request is accepted
//   readdata/readdatavalid          : read response, readdatavalid is a one-cycle pulse
// master modport: the requesting side.  slave modport: the arbiter side.
interface regrw16_arbiter_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned BE_W   = DATA_W / 8
);
   logic [DATA_W-1:0] writedata;
   logic [BE_W-1:0]   byteenable;
   logic              write;
   logic              read;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output writedata, byteenable, write, read,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  writedata, byteenable, write, read,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/regrw16_arbiter.sv
// Round-robin arbiter sharing one zero-wait Avalon-MM register slave between two masters.
//   csi_MCLK_clk        : clock
//   rsi_MRST_reset      : synchronous active-high reset
//   avs_M0, avs_M1      : upstream Avalon-MM slave ports (slave modport)
//   avm_Reg_*           : downstream master port; readdata is valid in the strobe cycle
// One transfer every two cycles: IDLE picks a winner, GRANT issues the slave strobe.
module regrw16_arbiter #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned BE_W   = DATA_W / 8
) (
   input  logic              csi_MCLK_clk,
   input  logic              rsi_MRST_reset,
   regrw16_arbiter_if.slave  avs_M0,
   regrw16_arbiter_if.slave  avs_M1,
   output logic [DATA_W-1:0] avm_Reg_writedata,
   output logic [BE_W-1:0]   avm_Reg_byteenable,
   output logic              avm_Reg_write,
   output logic              avm_Reg_read,
   input  logic [DATA_W-1:0] avm_Reg_readdata
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t            state;
   logic              sel;         // 0 = M0, 1 = M1
   logic              last_grant;  // master granted most recently
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic              rdv0;
   logic              rdv1;

   logic              req0;
   logic              req1;
   logic              win;
   logic              grant_c;
   logic              wr_sel;
   logic              rd_sel;
   logic [DATA_W-1:0] wd_sel;
   logic [BE_W-1:0]   be_sel;

   assign req0 = avs_M0.write | avs_M0.read;
   assign req1 = avs_M1.write | avs_M1.read;

   // Winner: the lone requester, or on a tie the master that did not win last.
   always_comb begin
      win = 1'b0;
      if (req0 && req1) begin
         win = ~last_grant;
      end else if (req1) begin
         win = 1'b1;
      end
   end

   // Reset in the GRANT cycle suppresses the strobe and the handshake.
   assign grant_c = (state == GRANT) && !rsi_MRST_reset;

   // Live signals of the selected master.
   assign wr_sel = sel ? avs_M1.write      : avs_M0.write;
   assign rd_sel = sel ? avs_M1.read       : avs_M0.read;
   assign wd_sel = sel ? avs_M1.writedata  : avs_M0.writedata;
   assign be_sel = sel ? avs_M1.byteenable : avs_M0.byteenable;

   // Write wins over a simultaneous read, so the two strobes are exclusive.
   assign avm_Reg_write      = grant_c & wr_sel;
   assign avm_Reg_read       = grant_c & ~wr_sel & rd_sel;
   assign avm_Reg_writedata  = grant_c ? wd_sel : '0;
   assign avm_Reg_byteenable = grant_c ? be_sel : '0;

   assign avs_M0.waitrequest   = ~(grant_c & ~sel);
   assign avs_M1.waitrequest   = ~(grant_c &  sel);
   assign avs_M0.readdata      = rdata0;
   assign avs_M1.readdata      = rdata1;
   assign avs_M0.readdatavalid = rdv0;
   assign avs_M1.readdatavalid = rdv1;

   // Arbitration FSM and registered read response.
   always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
         state      <= IDLE;
         sel        <= 1'b0;
         last_grant <= 1'b1;
         rdata0     <= '0;
         rdata1     <= '0;
         rdv0       <= 1'b0;
         rdv1       <= 1'b0;
      end else begin
         rdv0 <= 1'b0;
         rdv1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state      <= GRANT;
                  sel        <= win;
                  last_grant <= win;
               end
            end
            GRANT: begin
               state <= IDLE;
               if (avm_Reg_read) begin
                  if (sel) begin
                     rdata1 <= avm_Reg_readdata;
                     rdv1   <= 1'b1;
                  end else begin
                     rdata0 <= avm_Reg_readdata;
                     rdv0   <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
